// File: rtl/mux_arb_2x1_pkg.sv
// Shared types and defaults for the two-requester burst arbiter.
// Holds the grant-state encoding and datapath/burst defaults.
package mux_arb_2x1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int WIDTH_DEF     = 3;
    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_W_DEF     = 2;

endpackage

// File: rtl/mux_arb_2x1_mux.sv
// Plain 2:1 data mux shared by both requesters.
// sel = 1 routes in1 to the output.
module mux_2x1_3bit #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_arb_2x1.sv
// Round-robin burst arbiter over a shared 2:1 mux with a
// one-entry registered output stage (valid/ready).
module mux_arb_2x1
    import mux_arb_2x1_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             last0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             last1,
    output logic             ack1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;

    logic [WIDTH-1:0] mux_data;
    logic             cur_req;
    logic             cur_last;
    logic             oth_req;
    logic             slot_free;
    logic             xfer;
    logic             release_gnt;

    assign sel  = (state_q == GNT1);
    assign busy = (state_q != IDLE);

    mux_2x1_3bit #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in0 (data0),
        .in1 (data1),
        .sel (sel),
        .out (mux_data)
    );

    assign cur_req   = sel ? req1  : req0;
    assign cur_last  = sel ? last1 : last0;
    assign oth_req   = sel ? req0  : req1;
    assign slot_free = !out_valid_q || out_ready;

    // Reset gates the handshake so no beat is acked while it is dropped.
    assign xfer = rst_n && busy && cur_req && slot_free;

    assign ack0 = xfer && (state_q == GNT0);
    assign ack1 = xfer && (state_q == GNT1);

    assign release_gnt = !cur_req ||
        (xfer && (cur_last || (cnt_q == LAST_BEAT)));

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_src_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = prio_q ? GNT1 : GNT0;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (release_gnt) begin
                    prio_d  = ~sel;
                    cnt_d   = '0;
                    state_d = oth_req ? (sel ? GNT0 : GNT1) : IDLE;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/mux_arb_2x1.md
Name: mux_arb_2x1

Overview:
- Two-requester round-robin arbiter that shares a single WIDTH-bit datapath, the 2:1 3-bit mux, between two sources.
- Sequences grants as bursts and exports the mux select.
- Registers the winning beat into a one-entry output stage with a valid/ready handshake toward the consumer, such as the register-file write port.

Parameters:
- WIDTH, 3, data width of each requester and of the output.
- MAX_BURST, 4, maximum beats per grant before forced hand-over (≥1).
- CNT_W, 2, width of the beat counter. Must satisfy 2**CNT_W ≥ MAX_BURST.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req0  input  1  requester 0 has a beat pending.
- data0  input  WIDTH  requester 0 beat data.
- last0  input  1  current beat of requester 0 ends its burst.
- ack0  output  1  beat of requester 0 accepted this cycle.
- req1, data1, last1, ack1  same as above for requester 1.
- sel  output  1  mux select: 1 = requester 1 owns the datapath.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_data  output  WIDTH  registered beat.
- out_src  output  1  source index of out_data.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  a grant is active (state ≠ IDLE).

Behaviour:
- Single clock domain clk. rst_n is synchronous, active-low, and sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE, prio = 0, beat_cnt = 0.
  - out_valid = 0, out_data = 0, out_src = 0.
  - sel = 0, busy = 0, ack0 = ack1 = 0.
- FSM has three states: IDLE, GNT0, GNT1.
- IDLE transitions:
  - Only req0 → GNT0.
  - Only req1 → GNT1.
  - Both → GNT(prio).
  - Neither → stay.
  - No beat transfers in IDLE. A grant always costs one arbitration cycle from IDLE.
- sel = (state == GNT1). busy = (state ≠ IDLE). Both are decoded from registered state.
- Transfer in GNTn: fires when req_n && (!out_valid || out_ready). On that cycle:
  - ack_n = 1 (combinational, same cycle).
  - out_data <= data_n, out_src <= n, out_valid <= 1 on the next edge.
  - beat_cnt increments.
- ack of the non-granted requester is always 0.
- Releasing a grant:
  - Release conditions: a transfer with last_n = 1; a transfer with beat_cnt == MAX_BURST-1; or req_n = 0 while in GNTn (abandon, no transfer).
  - On release: prio <= ~n, beat_cnt <= 0.
  - Next state: GNT(~n) if req(~n) is high in the release cycle, otherwise IDLE. Back-to-back hand-over has no bubble.
  - A requester never holds the grant for more than MAX_BURST consecutive beats while the other is requesting.
- Output stage:
  - If out_valid && out_ready and no transfer fires → out_valid <= 0.
  - A simultaneous consume and transfer loads the new beat and out_valid stays 1.
  - out_data and out_src are held stable while out_valid && !out_ready.
- Backpressure: while out_valid && !out_ready, there is no transfer and no ack. The grant and beat_cnt are held and the state does not change, except on req_n drop.
- Requesters must hold req_n and data_n stable until ack_n. Dropping req_n without ack is a legal abandon.
- Width rules:
  - beat_cnt is CNT_W bits and is compared against MAX_BURST-1 at CNT_W width.
  - No wrap-around occurs, because release happens at MAX_BURST-1.
- Reset mid-burst: an asserted rst_n clears everything on that edge. Any in-flight out_valid beat is dropped and no ack is issued during reset.

Decomposition:
- Shared package/header: state encodings (IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2) and the WIDTH / MAX_BURST defaults.
- One natural sub-module: the existing mux_2x1_3bit, instantiated with in0 = data0, in1 = data1, sel = sel. Its output feeds the out_data register.
- The arbiter FSM and the output register stay in this module.

Test Plan:
- Reset and single requester:
  - Stimulus: hold rst_n = 0 for 2 cycles; then req0 = 1, data0 = 3'b101, last0 = 1, out_ready = 1.
  - Required: all outputs 0 during reset. GNT0 next cycle with sel = 0. ack0 pulses one cycle. Next cycle out_valid = 1, out_data = 101, out_src = 0. Then IDLE.
- Contention and round-robin:
  - Stimulus: from reset, req0 = req1 = 1, single-beat bursts, out_ready = 1.
  - Required: grants alternate 0,1,0,1 with no idle cycle between hand-overs. out_src sequence is 0,1,0,1.
- Burst limit:
  - Stimulus: req0 held with last0 = 0, req1 = 1, data0 = 3'b011.
  - Required: exactly 4 ack0 pulses, then sel = 1 on the following cycle and ack1 asserts.
- Backpressure:
  - Stimulus: out_ready = 0 after the first beat 3'b100.
  - Required: out_valid = 1 and out_data = 100 are held. ack0 = 0 and beat_cnt is frozen. After raising out_ready, the next beat loads on the same edge the old one is consumed.
- Abandon:
  - Stimulus: in GNT1, drop req1 before ack.
  - Required: next state is IDLE, or GNT0 if req0 = 1. prio = 0. No ack1 is issued.
- Reset mid-burst:
  - Stimulus: assert rst_n = 0 during the 2nd beat of a GNT1 burst with out_valid = 1.
  - Required: next edge gives state = IDLE, out_valid = 0, sel = 0, prio = 0, and no ack during reset.
